// File: rtl/online_seq_r4.sv
// Sequencer for online_sub_r4: latches operands, streams digits MSD-first, collects N+1 result digits.
// Latency: done N+DELAY+2 cycles after the start edge; no backpressure, start ignored unless IDLE.
module online_seq_r4 #(
    parameter int N     = 6,
    parameter int C     = 3,
    parameter int DELAY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N*C-1:0]       x_in,
    input  logic [N*C-1:0]       y_in,
    input  logic [(N+1)*C-1:0]   expected,
    input  logic [C-1:0]         zi,
    output logic                 sub_reset,
    output logic                 sub_en,
    output logic [C-1:0]         xi,
    output logic [C-1:0]         yi,
    output logic                 busy,
    output logic                 done,
    output logic [(N+1)*C-1:0]   result,
    output logic                 match
);

    localparam int KW = $clog2(N + DELAY + 1);
    localparam int OW = N * C;
    localparam int RW = (N + 1) * C;
    localparam logic [KW-1:0] K_LAST = KW'(N + DELAY - 1);
    localparam logic [KW-1:0] K_KEEP = KW'(DELAY);

    typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

    state_t          state, state_n;
    logic [KW-1:0]   k;
    logic [KW-1:0]   k_plus;
    logic [OW-1:0]   x_sr, y_sr;
    logic [RW-1:0]   acc, acc_n;
    logic            sub_reset_d, sub_en_d, busy_d, done_d;

    assign k_plus = k + 1'b1;
    assign acc_n  = {acc[RW-C-1:0], zi};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = CLR;
            CLR:     state_n = RUN;
            RUN:     if (k == K_LAST) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they are registered yet cycle-aligned.
    always_comb begin
        sub_reset_d = (state_n == CLR);
        sub_en_d    = (state_n == RUN);
        busy_d      = (state_n == CLR) || (state_n == RUN);
        done_d      = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_reset <= 1'b0;
            sub_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            xi        <= '0;
            yi        <= '0;
            x_sr      <= '0;
            y_sr      <= '0;
            acc       <= '0;
            result    <= '0;
            match     <= 1'b0;
            k         <= '0;
        end else begin
            sub_reset <= sub_reset_d;
            sub_en    <= sub_en_d;
            busy      <= busy_d;
            done      <= done_d;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_sr   <= x_in;
                        y_sr   <= y_in;
                        acc    <= '0;
                        result <= '0;
                    end
                end
                CLR: begin
                    xi   <= x_sr[OW-1 -: C];
                    yi   <= y_sr[OW-1 -: C];
                    x_sr <= x_sr << C;
                    y_sr <= y_sr << C;
                    k    <= '0;
                end
                RUN: begin
                    k <= k_plus;
                    // The first DELAY-1 samples are the unit's warm-up and are dropped.
                    if (k_plus >= K_KEEP) acc <= acc_n;
                    if (k == K_LAST) begin
                        xi     <= '0;
                        yi     <= '0;
                        result <= acc_n;
                        match  <= (acc_n == expected);
                    end else begin
                        xi   <= x_sr[OW-1 -: C];
                        yi   <= y_sr[OW-1 -: C];
                        x_sr <= x_sr << C;
                        y_sr <= y_sr << C;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_online_seq_r4.sv
// Directed bench for online_seq_r4 with a stub unit that returns zi = k[2:0] in RUN cycle k.
module tb_online_seq_r4;

    logic        clk;
    logic        reset;
    logic        start;
    logic [17:0] x_in, y_in;
    logic [20:0] expected;
    logic [2:0]  zi;
    logic        sub_reset, sub_en, busy, done, match;
    logic [2:0]  xi, yi;
    logic [20:0] result;

    int total = 0;
    int bad   = 0;

    online_seq_r4 #(.N(6), .C(3), .DELAY(2)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x_in(x_in), .y_in(y_in), .expected(expected), .zi(zi),
        .sub_reset(sub_reset), .sub_en(sub_en), .xi(xi), .yi(yi),
        .busy(busy), .done(done), .result(result), .match(match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub unit: counts enabled cycles since its reset.
    logic [3:0] kk;
    always @(posedge clk or posedge reset) begin
        if (reset)          kk <= 4'd0;
        else if (sub_reset) kk <= 4'd0;
        else if (sub_en)    kk <= kk + 4'd1;
    end
    assign zi = kk[2:0];

    typedef struct {
        logic [17:0] x;
        logic [17:0] y;
        logic [20:0] e;
        logic [23:0] exs;
        logic [23:0] eys;
        logic        em;
        bit          extra;
        bit          chg;
    } vec_t;

    vec_t tv[4];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Issues one start and observes a 14-cycle window; i counts negedges after the start edge.
    task automatic do_run(input vec_t v,
                          output logic [23:0] xs, output logic [23:0] ys,
                          output int sr_n, output int sr_at, output int en_n, output int en_at,
                          output int dn_n, output int dn_at, output int busy_bad,
                          output logic [20:0] res, output logic m);
        xs = '0; ys = '0; sr_n = 0; sr_at = -1; en_n = 0; en_at = -1;
        dn_n = 0; dn_at = -1; busy_bad = 0; res = '0; m = 1'b0;
        @(negedge clk);
        x_in = v.x; y_in = v.y; expected = v.e; start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (sub_reset) begin sr_n++; if (sr_at < 0) sr_at = i; end
            if (sub_en) begin
                en_n++;
                if (en_at < 0) en_at = i;
                xs = {xs[20:0], xi};
                ys = {ys[20:0], yi};
            end
            if (done) begin dn_n++; if (dn_at < 0) dn_at = i; res = result; m = match; end
            if (busy !== (i <= 9)) busy_bad++;
            start = v.extra && (i == 1 || i == 5 || i == 10);
            if (v.chg && i == 4) x_in = 18'o777777;
        end
    endtask

    logic [23:0] xs, ys;
    int          sr_n, sr_at, en_n, en_at, dn_n, dn_at, busy_bad;
    logic [20:0] res, prev_res;
    logic        m;
    int          cnt_done, cnt_sr, ndn, res_bad, viol;
    int          dpos[4];

    initial begin
        tv[0] = '{18'o123456, 18'o654321, 21'o1234567, 24'o12345600, 24'o65432100, 1'b1, 1'b0, 1'b0};
        tv[1] = '{18'o123456, 18'o654321, 21'o1234566, 24'o12345600, 24'o65432100, 1'b0, 1'b0, 1'b0};
        tv[2] = '{18'o707070, 18'o000001, 21'o1234567, 24'o70707000, 24'o00000100, 1'b1, 1'b1, 1'b0};
        tv[3] = '{18'o135724, 18'o246135, 21'o0000000, 24'o13572400, 24'o24613500, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; x_in = '0; y_in = '0; expected = '0;
        repeat (2) @(negedge clk);
        check("reset_ctrl", {sub_reset, sub_en, busy, done, match}, 5'b0);
        check("reset_data", {xi, yi, result}, 27'b0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {sub_reset, sub_en, busy, done}, 4'b0);

        for (int t = 0; t < 4; t++) begin
            do_run(tv[t], xs, ys, sr_n, sr_at, en_n, en_at, dn_n, dn_at, busy_bad, res, m);
            check($sformatf("v%0d_xi_stream", t), xs, tv[t].exs);
            check($sformatf("v%0d_yi_stream", t), ys, tv[t].eys);
            check($sformatf("v%0d_sub_reset_cnt", t), sr_n, 1);
            check($sformatf("v%0d_sub_reset_at", t), sr_at, 1);
            check($sformatf("v%0d_sub_en_cnt", t), en_n, 8);
            check($sformatf("v%0d_sub_en_at", t), en_at, 2);
            check($sformatf("v%0d_done_cnt", t), dn_n, 1);
            check($sformatf("v%0d_done_at", t), dn_at, 10);
            check($sformatf("v%0d_busy_shape", t), busy_bad, 0);
            check($sformatf("v%0d_result", t), res, 21'o1234567);
            check($sformatf("v%0d_match", t), m, tv[t].em);
        end

        // Reset in RUN cycle 4 (negedge 6 after the start edge).
        @(negedge clk);
        x_in = 18'o123456; y_in = 18'o654321; expected = 21'o1234567; start = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("midrun_sub_en_before", sub_en, 1'b1);
        reset = 1'b1;
        #1;
        check("midrun_reset_ctrl", {sub_reset, sub_en, busy, done, match}, 5'b0);
        check("midrun_reset_data", {xi, yi, result}, 27'b0);
        @(negedge clk);
        reset = 1'b0;
        cnt_done = 0; cnt_sr = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) cnt_done++;
            if (sub_reset || busy) cnt_sr++;
        end
        check("midrun_no_done", cnt_done, 0);
        check("midrun_idle", cnt_sr, 0);
        do_run(tv[0], xs, ys, sr_n, sr_at, en_n, en_at, dn_n, dn_at, busy_bad, res, m);
        check("post_reset_done_at", dn_at, 10);
        check("post_reset_result", res, 21'o1234567);
        check("post_reset_match", m, 1'b1);

        // start held high for 30 cycles: back-to-back operations.
        @(negedge clk);
        x_in = 18'o123456; y_in = 18'o654321; expected = 21'o1234567; start = 1'b1;
        ndn = 0; res_bad = 0; viol = 0; prev_res = result;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (done) begin
                if (ndn < 4) dpos[ndn] = i;
                ndn++;
                if (result !== 21'o1234567) res_bad++;
            end
            if (result !== prev_res && !done && !sub_reset) viol++;
            prev_res = result;
            if (i == 30) start = 1'b0;
        end
        check("b2b_done_cnt", ndn, 3);
        if (ndn >= 3) begin
            check("b2b_first_done", dpos[0], 10);
            check("b2b_gap1", dpos[1] - dpos[0], 11);
            check("b2b_gap2", dpos[2] - dpos[1], 11);
        end
        check("b2b_results", res_bad, 0);
        check("b2b_result_only_at_done", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
